// File: rtl/maxnet_pkg.sv
// Shared types and constants for the 4-neuron MAXNET sequencing controller.
// Used by the controller top and by its one-hot index decoder.
package maxnet_pkg;

    localparam int NUM_NEURONS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SUM    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [NUM_NEURONS-1:0] SEL_N0 = 4'b0001;
    localparam logic [NUM_NEURONS-1:0] SEL_N1 = 4'b0010;
    localparam logic [NUM_NEURONS-1:0] SEL_N2 = 4'b0100;
    localparam logic [NUM_NEURONS-1:0] SEL_N3 = 4'b1000;

    localparam logic [1:0] SLOT_LAST = 2'd3;

    function automatic logic [NUM_NEURONS-1:0] slot_sel(
        input logic [1:0] slot
    );
        logic [NUM_NEURONS-1:0] sel;
        sel = SEL_N0;
        case (slot)
            2'd0: sel = SEL_N0;
            2'd1: sel = SEL_N1;
            2'd2: sel = SEL_N2;
            2'd3: sel = SEL_N3;
            default: sel = SEL_N0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/maxnet_ctrl_onehot_idx.sv
// One-hot to binary index decoder with an exactly-one-set flag.
// Any vector that is not one-hot yields index 0 and o_one low.
module onehot_idx
    import maxnet_pkg::*;
(
    input  logic [NUM_NEURONS-1:0] i_vec,
    output logic [1:0]             o_idx,
    output logic                   o_one
);

    always_comb begin
        o_idx = 2'd0;
        o_one = 1'b0;
        case (i_vec)
            SEL_N0: begin
                o_idx = 2'd0;
                o_one = 1'b1;
            end
            SEL_N1: begin
                o_idx = 2'd1;
                o_one = 1'b1;
            end
            SEL_N2: begin
                o_idx = 2'd2;
                o_one = 1'b1;
            end
            SEL_N3: begin
                o_idx = 2'd3;
                o_one = 1'b1;
            end
            default: begin
                o_idx = 2'd0;
                o_one = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/maxnet_ctrl.sv
// MAXNET controller: load, then CHECK/SUM/UPDATE iterations until one
// neuron survives, all die, or the iteration limit is reached.
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter logic [7:0] MAX_ITER = 8'd100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] nz_in,
    output logic                   ld_en,
    output logic [NUM_NEURONS-1:0] mux_sel,
    output logic                   mux_flag,
    output logic                   acc_clr,
    output logic                   acc_en,
    output logic [NUM_NEURONS-1:0] wr_en,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             winner,
    output logic                   no_winner,
    output logic                   timeout,
    output logic [7:0]             iter_cnt
);

    state_e     r_state;
    state_e     w_next;
    logic [1:0] r_slot;
    logic [7:0] r_iter;
    logic [1:0] r_winner;
    logic       r_no_win;
    logic       r_timeout;

    logic [1:0] w_idx;
    logic       w_one;
    logic       w_zero;
    logic       w_limit;
    logic       w_slot_last;
    logic       w_in_phase;

    onehot_idx u_idx (
        .i_vec (nz_in),
        .o_idx (w_idx),
        .o_one (w_one)
    );

    assign w_zero      = ~|nz_in;
    assign w_limit     = (r_iter == MAX_ITER);
    assign w_slot_last = (r_slot == SLOT_LAST);
    assign w_in_phase  = (r_state == ST_SUM) || (r_state == ST_UPDATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_one || w_zero || w_limit) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SUM;
                end
            end
            ST_SUM: begin
                if (w_slot_last) begin
                    w_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (w_slot_last) begin
                    w_next = ST_CHECK;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Slot wraps 3->0 between SUM and UPDATE, so each phase starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= 2'd0;
        end else if (w_in_phase && !w_slot_last) begin
            r_slot <= r_slot + 2'd1;
        end else begin
            r_slot <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter    <= 8'd0;
            r_winner  <= 2'd0;
            r_no_win  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_iter    <= 8'd0;
                r_winner  <= 2'd0;
                r_no_win  <= 1'b0;
                r_timeout <= 1'b0;
            end
            if ((r_state == ST_UPDATE) && w_slot_last
                && (r_iter != 8'hFF)) begin
                r_iter <= r_iter + 8'd1;
            end
            if (r_state == ST_CHECK) begin
                if (w_one) begin
                    r_winner <= w_idx;
                end else if (w_zero) begin
                    r_no_win <= 1'b1;
                end else if (w_limit) begin
                    r_no_win  <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // acc_clr fires on every CHECK; clearing before DONE is harmless.
    always_comb begin
        ld_en    = 1'b0;
        mux_sel  = 4'b0000;
        mux_flag = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        wr_en    = 4'b0000;
        done     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                ld_en = 1'b1;
            end
            ST_CHECK: begin
                acc_clr = 1'b1;
            end
            ST_SUM: begin
                mux_sel  = slot_sel(r_slot);
                mux_flag = 1'b1;
                acc_en   = 1'b1;
            end
            ST_UPDATE: begin
                mux_sel  = slot_sel(r_slot);
                mux_flag = 1'b1;
                wr_en    = slot_sel(r_slot);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign winner    = r_winner;
    assign no_winner = r_no_win;
    assign timeout   = r_timeout;
    assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: cycle-position reference model, directed runs
// with literal expectations, then randomized start/nz_in/reset traffic.
module tb_maxnet_ctrl;

    localparam logic [7:0] TB_MAX = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] nz_in = 4'b0000;

    logic       ld_en;
    logic [3:0] mux_sel;
    logic       mux_flag;
    logic       acc_clr;
    logic       acc_en;
    logic [3:0] wr_en;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       no_winner;
    logic       timeout;
    logic [7:0] iter_cnt;

    maxnet_ctrl #(.MAX_ITER(TB_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nz_in     (nz_in),
        .ld_en     (ld_en),
        .mux_sel   (mux_sel),
        .mux_flag  (mux_flag),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .no_winner (no_winner),
        .timeout   (timeout),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // Model: m_t counts cycles since the accepted start (1 = load), and
    // every iteration occupies 9 consecutive positions after that.
    int         m_t = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_iter = 8'd0;
    logic [1:0] m_win = 2'd0;
    bit         m_nw = 1'b0;
    bit         m_to = 1'b0;
    int         mk;
    int         mpc;

    assign mk  = (m_t >= 2) ? (m_t - 2) % 9 : 0;
    assign mpc = $countones(nz_in);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_done <= 1'b0;
            m_iter <= 8'd0;
            m_win  <= 2'd0;
            m_nw   <= 1'b0;
            m_to   <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t    <= 1;
                m_iter <= 8'd0;
                m_win  <= 2'd0;
                m_nw   <= 1'b0;
                m_to   <= 1'b0;
            end
        end else if (m_t >= 2 && mk == 0) begin
            if (mpc == 1) begin
                m_win  <= idx_of(nz_in);
                m_done <= 1'b1;
                m_t    <= 0;
            end else if (mpc == 0) begin
                m_nw   <= 1'b1;
                m_done <= 1'b1;
                m_t    <= 0;
            end else if (m_iter == TB_MAX) begin
                m_nw   <= 1'b1;
                m_to   <= 1'b1;
                m_done <= 1'b1;
                m_t    <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            if (m_t >= 2 && mk == 8 && m_iter != 8'hFF) m_iter <= m_iter + 8'd1;
            m_t <= m_t + 1;
        end
    end

    task automatic compare_now();
        bit         in_run;
        bit         is_chk;
        bit         is_sum;
        bit         is_upd;
        logic [3:0] esel;
        in_run = (m_t >= 2);
        is_chk = in_run && (mk == 0);
        is_sum = in_run && (mk >= 1) && (mk <= 4);
        is_upd = in_run && (mk >= 5);
        esel = 4'b0000;
        if (is_sum) esel = 4'(1 << (mk - 1));
        if (is_upd) esel = 4'(1 << (mk - 5));
        chk("busy", 32'(busy), 32'((m_t != 0) || m_done));
        chk("done", 32'(done), 32'(m_done));
        chk("ld_en", 32'(ld_en), 32'(m_t == 1));
        chk("mux_sel", 32'(mux_sel), 32'(esel));
        chk("mux_flag", 32'(mux_flag), 32'(esel != 4'b0000));
        chk("acc_en", 32'(acc_en), 32'(is_sum));
        chk("wr_en", 32'(wr_en), 32'(is_upd ? esel : 4'b0000));
        if (!is_chk) begin
            chk("acc_clr_idle", 32'(acc_clr), 32'(0));
        end else if (mpc > 1 && m_iter != TB_MAX) begin
            chk("acc_clr_chk", 32'(acc_clr), 32'(1));
        end
        chk("winner", 32'(winner), 32'(m_win));
        chk("no_winner", 32'(no_winner), 32'(m_nw));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("iter_cnt", 32'(iter_cnt), 32'(m_iter));
    endtask

    always @(negedge clk) begin
        #2;
        compare_now();
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One run: nz0 until iter_cnt==sw, then nz1; optional start pulses
    // while the third neuron is being written back.
    task automatic run_dir(input logic [3:0] nz0, input logic [3:0] nz1,
                           input int sw, input bit upd_start,
                           output int lat, output int nsel,
                           output int nwr);
        nz_in = nz0;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        nsel = 0;
        nwr = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (mux_sel != 4'b0000) nsel++;
            if (wr_en != 4'b0000) nwr++;
            if (32'(iter_cnt) == sw) nz_in = nz1;
            start = upd_start && (wr_en == 4'b0100);
            step();
            lat++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'(1));
    endtask

    int lat;
    int nsel;
    int nwr;
    int ndone;
    int guard;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mux_sel", 32'(mux_sel), 32'(0));
        chk("rst_iter", 32'(iter_cnt), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        step();

        run_dir(4'b0100, 4'b0100, 0, 1'b0, lat, nsel, nwr);
        chk("single_lat", 32'(lat), 32'(3));
        chk("single_win", 32'(winner), 32'(2));
        chk("single_iter", 32'(iter_cnt), 32'(0));
        chk("single_nsel", 32'(nsel), 32'(0));
        step();

        run_dir(4'b1111, 4'b0010, 2, 1'b0, lat, nsel, nwr);
        chk("two_it_lat", 32'(lat), 32'(21));
        chk("two_it_win", 32'(winner), 32'(1));
        chk("two_it_iter", 32'(iter_cnt), 32'(2));
        chk("two_it_nsel", 32'(nsel), 32'(16));
        chk("two_it_nwr", 32'(nwr), 32'(8));
        chk("two_it_nw", 32'(no_winner), 32'(0));
        step();

        run_dir(4'b0011, 4'b0000, 1, 1'b0, lat, nsel, nwr);
        chk("zero_lat", 32'(lat), 32'(12));
        chk("zero_nw", 32'(no_winner), 32'(1));
        chk("zero_to", 32'(timeout), 32'(0));
        chk("zero_iter", 32'(iter_cnt), 32'(1));
        step();

        run_dir(4'b1111, 4'b1111, -1, 1'b0, lat, nsel, nwr);
        chk("tmo_lat", 32'(lat), 32'(30));
        chk("tmo_to", 32'(timeout), 32'(1));
        chk("tmo_nw", 32'(no_winner), 32'(1));
        chk("tmo_iter", 32'(iter_cnt), 32'(3));
        chk("tmo_nwr", 32'(nwr), 32'(12));
        step();
        chk("tmo_hold_iter", 32'(iter_cnt), 32'(3));
        chk("tmo_hold_to", 32'(timeout), 32'(1));

        run_dir(4'b1111, 4'b0010, 2, 1'b1, lat, nsel, nwr);
        chk("ign_lat", 32'(lat), 32'(21));
        chk("ign_win", 32'(winner), 32'(1));
        chk("ign_iter", 32'(iter_cnt), 32'(2));
        step();
        chk("ign_idle", 32'(busy), 32'(0));

        nz_in = 4'b0100;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            if (done === 1'b1) ndone++;
            step();
        end
        chk("hold2_runs", 32'(ndone), 32'(1));

        nz_in = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (mux_sel != 4'b0100 && guard < 50) begin
            step();
            guard++;
        end
        chk("rst_mid_reach", 32'(mux_sel), 32'(4'b0100));
        chk("rst_mid_acc", 32'(acc_en), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", 32'(mux_sel), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_done", 32'(done), 32'(0));
        step();
        nz_in = 4'b0001;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_start", 32'(ld_en), 32'(1));
        repeat (4) step();
        chk("post_rst_win", 32'(winner), 32'(0));
        chk("post_rst_nw", 32'(no_winner), 32'(0));

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) nz_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        start = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
